// File: rtl/debouncer_pkg.sv
//==============================================================================
// Module      : debouncer_pkg
// Description : Shared types and constants for the debouncer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package debouncer_pkg;

    typedef enum logic [0:0] {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    localparam int                     c_glitch_cnt_w   = 8;
    localparam logic [c_glitch_cnt_w-1:0] c_glitch_cnt_max = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/sync_chain.sv
//==============================================================================
// Module      : sync_chain
// Description : Multi-flop synchroniser for an asynchronous single-bit input.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/debouncer.sv
//==============================================================================
// Module      : debouncer
// Description : Synchronises and debounces a bouncing pad input. Optional
//               rejected-change counter enabled by DEBOUNCER_GLITCH_CNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module debouncer
    import debouncer_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_i,
    output logic                      level_o,
    output logic                      busy_o
`ifdef DEBOUNCER_GLITCH_CNT_EN
    ,
    output logic [c_glitch_cnt_w-1:0] glitch_cnt_o
`endif
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               w_sync;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_lvl;
    logic               w_lvl_nxt;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (a_i),
        .q_o   (w_sync)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lvl_nxt   = r_lvl;
        case (r_state)
            STABLE: begin
                if (w_sync != r_lvl) begin
                    w_state_nxt = CHECK;
                    w_cnt_nxt   = '0;
                end
            end
            CHECK: begin
                if (w_sync == r_lvl) begin
                    w_state_nxt = STABLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = STABLE;
                    w_lvl_nxt   = w_sync;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = STABLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_lvl   <= RESET_LEVEL;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lvl   <= w_lvl_nxt;
        end
    end

    assign level_o = r_lvl;
    assign busy_o  = (r_state == CHECK);

`ifdef DEBOUNCER_GLITCH_CNT_EN
    // A glitch is a candidate that reverts before qualification completes.
    logic                      w_glitch;
    logic [c_glitch_cnt_w-1:0] r_glitch_cnt;

    assign w_glitch = (r_state == CHECK) && (w_sync == r_lvl);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && (r_glitch_cnt != c_glitch_cnt_max)) begin
            r_glitch_cnt <= r_glitch_cnt + 1'b1;
        end
    end

    assign glitch_cnt_o = r_glitch_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_debouncer.sv
//==============================================================================
// Module      : tb_debouncer
// Description : Directed scoreboard bench for debouncer (default parameters).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_debouncer;

    localparam int   SYNC = 2;
    localparam int   DC   = 16;
    localparam int   LAT  = SYNC + DC;

    logic clk = 1'b0;
    logic reset;
    logic a_i;
    logic level_o;
    logic busy_o;
`ifdef DEBOUNCER_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_o;
`endif

    always #5 clk = ~clk;

    debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DC),
        .RESET_LEVEL     (1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .a_i          (a_i),
        .level_o      (level_o),
        .busy_o       (busy_o)
`ifdef DEBOUNCER_GLITCH_CNT_EN
        ,
        .glitch_cnt_o (glitch_cnt_o)
`endif
    );

    typedef struct {
        string tag;
        int    at;
        int    lvl;
        int    busy;
        int    gc;
    } exp_t;

    exp_t sb[$];
    exp_t it;
    int   cyc         = 0;
    int   total       = 0;
    int   bad         = 0;
    int   last_change = -1000;
    logic prev_level  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Negative value in a field means "don't check this output".
    function automatic void expect_at(string tag, int at, int l, int b, int gc);
        exp_t e;
        e.tag = tag; e.at = at; e.lvl = l; e.busy = b; e.gc = gc;
        sb.push_back(e);
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at == cyc) begin
            it = sb.pop_front();
            if (it.lvl >= 0) begin
                total++;
                assert (level_o === it.lvl[0]) else begin
                    bad++;
                    $error("FAIL %s level_o got=%b exp=%b cyc=%0d", it.tag, level_o, it.lvl[0], cyc);
                end
            end
            if (it.busy >= 0) begin
                total++;
                assert (busy_o === it.busy[0]) else begin
                    bad++;
                    $error("FAIL %s busy_o got=%b exp=%b cyc=%0d", it.tag, busy_o, it.busy[0], cyc);
                end
            end
`ifdef DEBOUNCER_GLITCH_CNT_EN
            if (it.gc >= 0) begin
                total++;
                assert (glitch_cnt_o === it.gc[7:0]) else begin
                    bad++;
                    $error("FAIL %s glitch_cnt_o got=%0d exp=%0d cyc=%0d", it.tag, glitch_cnt_o, it.gc, cyc);
                end
            end
`endif
        end
        if (level_o !== prev_level) begin
            total++;
            assert (cyc - last_change >= DC + 1) else begin
                bad++;
                $error("FAIL level_spacing got=%0d exp>=%0d cyc=%0d", cyc - last_change, DC + 1, cyc);
            end
            last_change = cyc;
            prev_level  = level_o;
        end
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog got=timeout exp=finish cyc=%0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        int m;
        reset = 1'b0;
        a_i   = 1'b0;

        // Reset state and the cycle after release
        step(1);
        expect_at("rst_hold", cyc + 1, 0, 0, 0);
        step(2);
        reset = 1'b1;
        expect_at("rst_after", cyc + 1, 0, 0, 0);
        step(3);

        // Clean rising step: latency SYNC+DC
        a_i = 1'b1; n = cyc + 1;
        expect_at("rise_idle", n + 1,       0, 0, -1);
        expect_at("rise_busy", n + SYNC + 1, 0, 1, -1);
        expect_at("rise_pre",  n + LAT - 1, 0, 1, -1);
        expect_at("rise_done", n + LAT,     1, 0, 0);
        step(LAT + 3);

        // Clean falling step
        a_i = 1'b0; n = cyc + 1;
        expect_at("fall_busy", n + SYNC + 1, 1, 1, -1);
        expect_at("fall_pre",  n + LAT - 1, 1, 1, -1);
        expect_at("fall_done", n + LAT,     0, 0, 0);
        step(LAT + 3);

        // Candidate one short of qualification is rejected
        a_i = 1'b1; n = cyc + 1;
        expect_at("rej_busy", n + SYNC + 1, 0, 1, -1);
        step(DC - 1);
        a_i = 1'b0;
        expect_at("rej_after", n + LAT + 1, 0, 0, 1);
        step(LAT + 3);

        // Candidate held through full qualification is accepted, then released
        a_i = 1'b1; n = cyc + 1;
        expect_at("acc_pre",  n + LAT - 1, 0, 1, -1);
        expect_at("acc_done", n + LAT,     1, 0, 1);
        step(DC + 1);
        a_i = 1'b0; n = cyc + 1;
        expect_at("acc_fall_pre",  n + LAT - 1, 1, 1, -1);
        expect_at("acc_fall_done", n + LAT,     0, 0, 1);
        step(LAT + 3);

        // Reset in the middle of CHECK with cnt = 8
        a_i = 1'b1; n = cyc + 1;
        expect_at("mid_busy", n + SYNC + 1, 0, 1, -1);
        step(SYNC + 9);
        reset = 1'b0;
        expect_at("mid_rst", cyc + 1, 0, 0, 0);
        step(1);
        reset = 1'b1; m = cyc + 1;
        expect_at("post_rst_pre",  m + LAT - 1, 0, 1, -1);
        expect_at("post_rst_done", m + LAT,     1, 0, 0);
        step(LAT + 2);
        a_i = 1'b0; n = cyc + 1;
        expect_at("post_rst_fall", n + LAT, 0, 0, 0);
        step(LAT + 3);

        // Bounce train: every pulse rejected, counter saturates
        for (int k = 0; k < 300; k++) begin
            a_i = 1'b1;
            expect_at("bounce_lvl", cyc + 2, 0, -1, -1);
            step(3);
            a_i = 1'b0;
            step(3);
            if (k == 99) expect_at("bounce_100", cyc + SYNC - 1, 0, 0, 100);
        end
        step(5);
        expect_at("bounce_sat", cyc + 1, 0, 0, 255);
        step(3);

        total++;
        assert (sb.size() === 0) else begin
            bad++;
            $error("FAIL sb_drain got=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
